// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, NOP encoding, fetch FSM states and reset PC.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_FETCH,
    FS_VALID,
    FS_DISCARD,
    FS_HALT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC resolution: branch/jump take decision, target select and
// alignment fault detection. Also used by the pipelined datapath.
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pcsrc_i,
  input  logic            pc_write_cond_i,
  input  logic            bne_i,
  input  logic            jalr_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic            take_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misalign_o
);

  assign take_o     = pcsrc_i | (pc_write_cond_i & (zero_i ^ bne_i));
  assign target_o   = jalr_i ? {jalr_target_i[XLEN-1:1], 1'b0} : branch_target_i;
  assign pc_plus4_o = pc_i + XLEN'(4);
  // Only bit 1 matters: bit 0 is cleared for JALR and branch immediates are even.
  assign misalign_o = take_o & target_o[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// holds the instruction register. Define FETCH_PREFETCH_EN for a one-entry prefetch buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      func3_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic            pcsrc_i,
  input  logic            pc_write_cond_i,
  input  logic            bne_i,
  input  logic            jalr_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic            misalign_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            out_q, out_d;
  logic            misalign_q, misalign_d;
`ifdef FETCH_PREFETCH_EN
  logic            pf_full_q, pf_full_d;
  logic [31:0]     pf_data_q, pf_data_d;
`endif

  logic            sel_take, sel_misalign;
  logic [XLEN-1:0] sel_target, sel_pc_plus4, next_pc;
  logic            consume, accept;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc_i            (pc_q),
    .pcsrc_i         (pcsrc_i),
    .pc_write_cond_i (pc_write_cond_i),
    .bne_i           (bne_i),
    .jalr_i          (jalr_i),
    .zero_i          (zero_i),
    .branch_target_i (branch_target_i),
    .jalr_target_i   (jalr_target_i),
    .take_o          (sel_take),
    .target_o        (sel_target),
    .pc_plus4_o      (sel_pc_plus4),
    .misalign_o      (sel_misalign)
  );

  assign next_pc = sel_take ? sel_target : sel_pc_plus4;
  assign consume = (state_q == FS_VALID) & inst_ready_i;
  // A response is only believed once its request has left the bus, so a stale
  // strobe landing in the cycle of a fresh request (e.g. right after reset) is dropped.
  assign accept  = imem_rvalid_i & out_q & ~req_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
    misalign_d = misalign_q;
`ifdef FETCH_PREFETCH_EN
    pf_full_d  = pf_full_q;
    pf_data_d  = pf_data_q;
`endif
    case (state_q)
      FS_IDLE: begin
        req_d   = 1'b1;
        addr_d  = pc_q;
        state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (accept) begin
          inst_d  = imem_rdata_i;
          state_d = FS_VALID;
        end
      end
      FS_VALID: begin
        if (consume) begin
          if (sel_misalign) begin
            misalign_d = 1'b1;
            state_d    = FS_HALT;
`ifdef FETCH_PREFETCH_EN
            pf_full_d  = 1'b0;
`endif
          end else begin
            pc_d = next_pc;
`ifdef FETCH_PREFETCH_EN
            if (!sel_take && pf_full_q) begin
              inst_d    = pf_data_q;
              pf_full_d = 1'b0;
            end else if (!sel_take && accept) begin
              inst_d = imem_rdata_i;
            end else if (!sel_take && out_q) begin
              state_d = FS_FETCH;
            end else if (sel_take && out_q && !accept) begin
              state_d = FS_DISCARD;
            end else begin
              req_d     = 1'b1;
              addr_d    = next_pc;
              pf_full_d = 1'b0;
              state_d   = FS_FETCH;
            end
`else
            req_d   = 1'b1;
            addr_d  = next_pc;
            state_d = FS_FETCH;
`endif
          end
        end
`ifdef FETCH_PREFETCH_EN
        else if (accept) begin
          pf_full_d = 1'b1;
          pf_data_d = imem_rdata_i;
        end else if (!out_q && !pf_full_q) begin
          req_d  = 1'b1;
          addr_d = sel_pc_plus4;
        end
`endif
      end
`ifdef FETCH_PREFETCH_EN
      FS_DISCARD: begin
        // pc_q already holds the redirect target; refetch once the wrong-path word drains.
        if (accept) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FS_FETCH;
        end
      end
`endif
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_IDLE;
    endcase
    out_d = (out_q & ~accept) | req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      out_q      <= 1'b0;
      misalign_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_full_q  <= 1'b0;
      pf_data_q  <= NOP_INST;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      misalign_q <= misalign_d;
`ifdef FETCH_PREFETCH_EN
      pf_full_q  <= pf_full_d;
      pf_data_q  <= pf_data_d;
`endif
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (state_q == FS_VALID);
  assign inst_o       = inst_q;
  assign opcode_o     = inst_q[6:0];
  assign func3_o      = inst_q[14:12];
  assign pc_o         = pc_q;
  assign pc_plus4_o   = sel_pc_plus4;
  assign misalign_o   = misalign_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the single-cycle RISC-V control unit. Owns the PC and issues requests to instruction memory. Holds the fetched instruction in an instruction register and presents opcode/func3 to the control unit through a valid/ready handshake. Resolves the next PC from the control unit's branch/jump outputs when each instruction is consumed.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset
- XLEN, 32, address/data width

Ports:
- clk  in  1  rising-edge clock; the only clock in the block
- rst_n  in  1  reset, asynchronous and active-low
- imem_req_o  in/out: out  1  one-cycle request pulse
- imem_addr_o  out  XLEN  request address, valid with imem_req_o
- imem_rvalid_i  in  1  response strobe
- imem_rdata_i  in  32  instruction word, valid with imem_rvalid_i
- inst_valid_o  out  1  instruction register holds a consumable instruction
- inst_ready_i  in  1  datapath consumes the instruction this cycle
- inst_o  out  32  instruction register
- opcode_o  out  7  inst_o[6:0], to control unit
- func3_o  out  3  inst_o[14:12], to control unit
- pc_o  out  XLEN  PC of inst_o
- pc_plus4_o  out  XLEN  pc_o + 4, for JAL/JALR link
- pcsrc_i, pc_write_cond_i, bne_i, jalr_i  in  1 each  from control unit
- zero_i  in  1  ALU zero flag
- branch_target_i  in  XLEN  pc_o + immediate
- jalr_target_i  in  XLEN  rs1 + immediate
- misalign_o  out  1  sticky; taken target not word-aligned

## Operation
- States: IDLE, FETCH, VALID, DISCARD, HALT. Reset enters IDLE.
- IDLE: issue the request for the PC and go to FETCH.
- FETCH: wait for imem_rvalid_i, load inst_o, then go to VALID.
- VALID: inst_valid_o=1. Consume happens when inst_valid_o & inst_ready_i.
- take = pcsrc_i | (pc_write_cond_i & (zero_i ^ bne_i)).
- target = jalr_i ? {jalr_target_i[31:1],1'b0} : branch_target_i.
- On consume: next PC = take ? target : pc_o+4, and a request for it is issued.
- If target[1] is set on a taken consume: set misalign_o, go to HALT, issue no request. HALT is left only by reset.
- At most one request is outstanding. imem_rvalid_i with nothing outstanding is ignored.
- All address arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- Branch inputs are sampled only in the consume cycle.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=RESET_PC, misalign_o=0.
- The first imem_req_o occurs in the first clk edge after rst_n deasserts.
- imem_req_o and imem_addr_o are registered. A request follows a consume by 1 cycle.
- rdata is captured on the rvalid edge; inst_valid_o rises on the next cycle.
- Without prefetch, with 1-cycle memory, sustained rate is 1 instruction per 3 cycles.
- inst_o, pc_o and inst_valid_o are stable while inst_valid_o=1 and inst_ready_i=0.
- rst_n asserted mid-transaction: immediate return to reset values. Any later rvalid for the old request is ignored.

## Configuration
- FETCH_PREFETCH_EN defined: in VALID, a speculative request for pc_o+4 is issued one cycle after inst_valid_o rises. The response is held in a one-entry prefetch buffer.
  - Non-taken consume with the buffer full: inst_o is loaded from the buffer and VALID is kept. inst_valid_o stays high, giving back-to-back consumes.
  - Non-taken consume with the speculative request in flight: go to FETCH.
  - Taken consume with the request in flight: go to DISCARD, drop the response, then request the target.
  - Taken consume with the buffer full: clear the buffer and request the target.
- FETCH_PREFETCH_EN undefined: no speculative request, no buffer, no DISCARD state.

## Structure
- Shared riscv_pkg holds: opcode constants, the NOP encoding, the fetch state enum, and RESET_PC default.
- One sub-module, next_pc_sel: combinational take/target/misalign computation. Shared later with the pipelined datapath.

## Test plan
- Reset release, 1-cycle memory returning 32'h00500093 -> req at 32'h0040_0000; inst_valid_o, opcode_o=7'b0010011, func3_o=0.
- BNE (bne_i=1, pc_write_cond_i=1, zero_i=0), branch_target_i=32'h0040_0020 -> next imem_addr_o=32'h0040_0020.
- JALR with jalr_target_i=32'h0040_0105 -> request 32'h0040_0104; target 32'h0040_0106 -> misalign_o=1, no further requests.
- inst_ready_i held low for 10 cycles -> inst_o and pc_o unchanged, no extra requests without prefetch.
- FETCH_PREFETCH_EN, 1-cycle memory, ready always high, straight-line code -> consumes every cycle once buffer filled; taken JAL mid-flight -> stale response dropped, next inst from target.
- rst_n pulsed low while a request is outstanding -> outputs at reset values, late rvalid ignored, fetch restarts at RESET_PC.
